pc_sequencer: RTL and testbench

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/pc_sequencer_pkg.sv | 16 +
 rtl/pc_sequencer_if.sv | 30 +++
 rtl/pc_ras_stack.sv | 61 ++++++
 rtl/pc_sequencer.sv | 124 ++++++++++++
 tb/tb_pc_sequencer.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: FSM state encoding and target alignment check.
package pc_sequencer_pkg;

  typedef enum logic [1:0] {
    StBoot,
    StRun,
    StHalt
  } seq_state_e;

  localparam logic [1:0] ALIGN_MASK = 2'b11;

  function automatic logic misaligned(input logic [1:0] lsb);
    return |(lsb & ALIGN_MASK);
  endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// Control/fetch bundle between the pipeline (master) and the PC sequencer (slave).
interface pc_sequencer_if #(
  parameter int unsigned XLEN = 32
);

  logic            stall;
  logic            halt;
  logic            redirect_valid;
  logic [XLEN-1:0] redirect_addr;
  logic            trap;
  logic [XLEN-1:0] trap_vec;
  logic            call;
  logic            ret;
  logic            fetch_ready;
  logic            fetch_valid;
  logic [XLEN-1:0] pc_out;
  logic            misalign_err;
  logic            ras_underflow;

  modport master (
    output stall, halt, redirect_valid, redirect_addr, trap, trap_vec, call, ret, fetch_ready,
    input  fetch_valid, pc_out, misalign_err, ras_underflow
  );

  modport slave (
    input  stall, halt, redirect_valid, redirect_addr, trap, trap_vec, call, ret, fetch_ready,
    output fetch_valid, pc_out, misalign_err, ras_underflow
  );

endinterface

// File: rtl/pc_ras_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
module pc_ras_stack #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic            pop,
  input  logic [XLEN-1:0] push_data,
  output logic [XLEN-1:0] top,
  output logic            empty,
  output logic            full
);

  localparam int unsigned PtrW = $clog2(RAS_DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [XLEN-1:0] mem_q [RAS_DEPTH];
  logic [PtrW-1:0] ptr_q, ptr_d, wr_ptr;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            wr_en;

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == CntW'(RAS_DEPTH));
  assign top   = mem_q[ptr_q];

  always_comb begin
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_ptr = ptr_q;
    if (push && pop && !empty) begin
      // Push and pop together replace the top entry in place.
      wr_en = 1'b1;
    end else if (push) begin
      wr_en  = 1'b1;
      wr_ptr = ptr_q + 1'b1;
      ptr_d  = ptr_q + 1'b1;
      if (!full) cnt_d = cnt_q + 1'b1;
    end else if (pop && !empty) begin
      ptr_d = ptr_q - 1'b1;
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst && wr_en) mem_q[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer with BOOT/RUN/HALT control, trap/redirect loads and fetch handshake.
// Define PC_SEQUENCER_RAS_EN to add the return-address stack (call/ret); otherwise call/ret are ignored.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter int unsigned     XLEN      = 32,
  parameter logic [XLEN-1:0] RESET_VEC = '0,
  parameter int unsigned     INC       = 4,
  parameter int unsigned     RAS_DEPTH = 4
) (
  input logic           clk,
  input logic           rst,
  pc_sequencer_if.slave bus
);

  seq_state_e      state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] pc_inc;
  logic            misalign_q, misalign_d;
  logic            underflow_q, underflow_d;
  logic            fetch_valid, fetch_fire;
  logic            call_en, ret_en;
  logic            ras_push, ras_pop, ras_empty;
  logic [XLEN-1:0] ras_top;

  assign fetch_valid = (state_q == StRun);
  assign fetch_fire  = fetch_valid && bus.fetch_ready && !bus.stall;
  assign pc_inc      = pc_q + XLEN'(INC);

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    misalign_d  = 1'b0;
    underflow_d = 1'b0;
    ras_push    = 1'b0;
    ras_pop     = 1'b0;
    if (bus.trap) begin
      // A rejected trap still outranks redirect: the cycle just holds and flags the error.
      if (misaligned(bus.trap_vec[1:0])) begin
        misalign_d = 1'b1;
      end else begin
        pc_d    = bus.trap_vec;
        state_d = StRun;
      end
    end else if (bus.redirect_valid) begin
      if (misaligned(bus.redirect_addr[1:0])) begin
        misalign_d = 1'b1;
      end else begin
        pc_d     = bus.redirect_addr;
        state_d  = StRun;
        ras_push = call_en;
        ras_pop  = call_en && ret_en && !ras_empty;
      end
    end else begin
      unique case (state_q)
        StBoot: state_d = StRun;
        StRun:  if (bus.halt) state_d = StHalt;
        StHalt: state_d = StHalt;
      endcase
      if (ret_en) begin
        if (ras_empty) begin
          underflow_d = 1'b1;
        end else begin
          pc_d    = ras_top;
          ras_pop = 1'b1;
        end
      end else if (fetch_fire && !bus.halt) begin
        pc_d = pc_inc;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= StBoot;
      pc_q        <= RESET_VEC;
      misalign_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      misalign_q  <= misalign_d;
      underflow_q <= underflow_d;
    end
  end

  assign bus.fetch_valid  = fetch_valid;
  assign bus.pc_out       = pc_q;
  assign bus.misalign_err = misalign_q;

`ifdef PC_SEQUENCER_RAS_EN
  logic ras_full;
  logic unused_full;

  assign call_en           = bus.call;
  assign ret_en            = bus.ret;
  assign bus.ras_underflow = underflow_q;
  assign unused_full       = ras_full;

  pc_ras_stack #(
    .XLEN      (XLEN),
    .RAS_DEPTH (RAS_DEPTH)
  ) u_ras (
    .clk       (clk),
    .rst       (rst),
    .push      (ras_push),
    .pop       (ras_pop),
    .push_data (pc_inc),
    .top       (ras_top),
    .empty     (ras_empty),
    .full      (ras_full)
  );
`else
  logic unused_ras;

  assign call_en           = 1'b0;
  assign ret_en            = 1'b0;
  assign ras_empty         = 1'b1;
  assign ras_top           = '0;
  assign bus.ras_underflow = 1'b0;
  assign unused_ras        = ^{bus.call, bus.ret, ras_push, ras_pop, underflow_q};
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer: a behavioural next-PC model checked every cycle plus literal pins.
module tb_pc_sequencer;

  localparam int unsigned XLEN      = 32;
  localparam logic [31:0] RESET_VEC = 32'h0;
  localparam logic [31:0] INC       = 32'd4;
  localparam int unsigned RAS_DEPTH = 4;
`ifdef PC_SEQUENCER_RAS_EN
  localparam bit RAS_ON = 1'b1;
`else
  localparam bit RAS_ON = 1'b0;
`endif

  localparam int M_BOOT = 0;
  localparam int M_RUN  = 1;
  localparam int M_HALT = 2;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  bit   check_en = 1'b0;

  pc_sequencer_if #(.XLEN(XLEN)) bus ();

  pc_sequencer #(
    .XLEN      (XLEN),
    .RESET_VEC (RESET_VEC),
    .INC       (32'd4),
    .RAS_DEPTH (RAS_DEPTH)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: stack as a queue, mode as a plain integer.
  logic [31:0] m_pc;
  int          m_mode;
  bit          m_mis, m_und, m_run;
  logic [31:0] m_stack[$];

  always @(posedge clk) begin
    if (!rst) begin
      m_pc   = RESET_VEC;
      m_mode = M_BOOT;
      m_mis  = 1'b0;
      m_und  = 1'b0;
      m_stack.delete();
    end else begin
      m_mis = 1'b0;
      m_und = 1'b0;
      m_run = (m_mode == M_RUN);
      if (bus.trap) begin
        if (bus.trap_vec[1:0] != 2'b00) m_mis = 1'b1;
        else begin
          m_pc   = bus.trap_vec;
          m_mode = M_RUN;
        end
      end else if (bus.redirect_valid) begin
        if (bus.redirect_addr[1:0] != 2'b00) m_mis = 1'b1;
        else begin
          if (RAS_ON && bus.call) begin
            if (bus.ret && m_stack.size() > 0) m_stack[m_stack.size()-1] = m_pc + INC;
            else begin
              if (m_stack.size() == RAS_DEPTH) void'(m_stack.pop_front());
              m_stack.push_back(m_pc + INC);
            end
          end
          m_pc   = bus.redirect_addr;
          m_mode = M_RUN;
        end
      end else begin
        if (m_mode == M_BOOT) m_mode = M_RUN;
        else if (m_run && bus.halt) m_mode = M_HALT;
        if (RAS_ON && bus.ret) begin
          if (m_stack.size() == 0) m_und = 1'b1;
          else m_pc = m_stack.pop_back();
        end else if (m_run && bus.fetch_ready && !bus.stall && !bus.halt) begin
          m_pc = m_pc + INC;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (check_en) begin
      check("model fetch_valid", 32'(bus.fetch_valid), 32'(m_mode == M_RUN));
      check("model pc_out", bus.pc_out, m_pc);
      check("model misalign_err", 32'(bus.misalign_err), 32'(m_mis));
      check("model ras_underflow", 32'(bus.ras_underflow), 32'(m_und));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_ctl();
    bus.stall          = 1'b0;
    bus.halt           = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_addr  = '0;
    bus.trap           = 1'b0;
    bus.trap_vec       = '0;
    bus.call           = 1'b0;
    bus.ret            = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    clear_ctl();
    bus.fetch_ready = 1'b1;
    tick(2);
    check("reset pc", bus.pc_out, 32'h0);
    check("reset fetch_valid", 32'(bus.fetch_valid), 32'h0);
    check_en = 1'b1;

    rst = 1'b1;
    tick();
    check("boot->run fetch_valid", 32'(bus.fetch_valid), 32'h1);
    check("first pc", bus.pc_out, 32'h0);
    tick();
    check("step pc 4", bus.pc_out, 32'h4);
    tick();
    check("step pc 8", bus.pc_out, 32'h8);
    tick(2);
    check("at 0x10", bus.pc_out, 32'h10);

    bus.fetch_ready = 1'b0;
    tick(3);
    check("ready low holds", bus.pc_out, 32'h10);
    bus.fetch_ready = 1'b1;
    tick();
    check("ready back", bus.pc_out, 32'h14);
    tick(3);
    check("at 0x20", bus.pc_out, 32'h20);

    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h102;
    tick();
    clear_ctl();
    check("misaligned hold", bus.pc_out, 32'h20);
    check("misalign pulse", 32'(bus.misalign_err), 32'h1);
    tick();
    check("misalign one cycle", 32'(bus.misalign_err), 32'h0);

    bus.trap           = 1'b1;
    bus.trap_vec       = 32'h80;
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h40;
    tick();
    clear_ctl();
    check("trap beats redirect", bus.pc_out, 32'h80);

    bus.stall = 1'b1;
    tick(2);
    clear_ctl();
    check("stall holds", bus.pc_out, 32'h80);

    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'hFFFF_FFFC;
    tick();
    clear_ctl();
    check("top of space", bus.pc_out, 32'hFFFF_FFFC);
    tick();
    check("wrap to zero", bus.pc_out, 32'h0);

    bus.halt = 1'b1;
    tick();
    clear_ctl();
    check("halt holds pc", bus.pc_out, 32'h0);
    check("halt fetch_valid", 32'(bus.fetch_valid), 32'h0);
    tick();
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h40;
    tick();
    clear_ctl();
    check("resume pc", bus.pc_out, 32'h40);
    check("resume fetch_valid", 32'(bus.fetch_valid), 32'h1);
    tick();

    bus.halt = 1'b1;
    tick();
    clear_ctl();
    bus.trap     = 1'b1;
    bus.trap_vec = 32'h81;
    tick();
    clear_ctl();
    check("bad trap keeps halt", 32'(bus.fetch_valid), 32'h0);
    check("bad trap pulse", 32'(bus.misalign_err), 32'h1);
    bus.trap     = 1'b1;
    bus.trap_vec = 32'h100;
    tick();
    clear_ctl();
    check("trap leaves halt", bus.pc_out, 32'h100);

`ifdef PC_SEQUENCER_RAS_EN
    bus.redirect_valid = 1'b1;
    bus.redirect_addr  = 32'h0;
    tick();
    for (int k = 1; k <= 5; k++) begin
      bus.call          = 1'b1;
      bus.redirect_addr = 32'(k) * 32'h100;
      tick();
    end
    clear_ctl();
    check("after calls", bus.pc_out, 32'h500);
    bus.fetch_ready = 1'b0;
    bus.ret         = 1'b1;
    tick();
    check("ret 1", bus.pc_out, 32'h404);
    tick();
    check("ret 2", bus.pc_out, 32'h304);
    tick();
    check("ret 3", bus.pc_out, 32'h204);
    tick();
    check("ret 4", bus.pc_out, 32'h104);
    tick();
    check("ret 5 underflow", 32'(bus.ras_underflow), 32'h1);
    check("ret 5 holds", bus.pc_out, 32'h104);
    clear_ctl();
    tick();
    check("underflow one cycle", 32'(bus.ras_underflow), 32'h0);

    bus.redirect_valid = 1'b1;
    bus.call           = 1'b1;
    bus.redirect_addr  = 32'h300;
    tick();
    bus.ret           = 1'b1;
    bus.redirect_addr = 32'h600;
    tick();
    clear_ctl();
    check("call+ret target", bus.pc_out, 32'h600);
    bus.ret = 1'b1;
    tick();
    check("replaced top", bus.pc_out, 32'h304);
    tick();
    check("count unchanged", 32'(bus.ras_underflow), 32'h1);
    clear_ctl();
    bus.fetch_ready = 1'b1;
    tick();
`else
    bus.ret = 1'b1;
    tick();
    clear_ctl();
    check("ret ignored pc", bus.pc_out, 32'h104);
    check("underflow tied low", 32'(bus.ras_underflow), 32'h0);
    bus.redirect_valid = 1'b1;
    bus.call           = 1'b1;
    bus.ret            = 1'b1;
    bus.redirect_addr  = 32'h200;
    tick();
    clear_ctl();
    check("call ignored pc", bus.pc_out, 32'h200);
    tick();
`endif

    rst          = 1'b0;
    bus.trap     = 1'b1;
    bus.trap_vec = 32'h80;
    tick();
    clear_ctl();
    check("reset beats trap pc", bus.pc_out, RESET_VEC);
    check("reset beats trap state", 32'(bus.fetch_valid), 32'h0);
    rst = 1'b1;
    tick();
    check("rerun pc", bus.pc_out, 32'h0);
    check("rerun fetch_valid", 32'(bus.fetch_valid), 32'h1);
    tick(2);
    check("rerun step", bus.pc_out, 32'h8);

    check_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
